// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin front end that time-shares one combinational 32x32 Karatsuba
// multiplier between N_REQ requesters. One operation is in flight at a time.
// The multiplier output is treated as a MUL_CYCLES multicycle path from
// a_q/b_q. The product is held until the consumer takes it.

// One-level Karatsuba 32x32 unsigned multiplier, purely combinational.
module karatsuba_mul_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] c
);

  logic [15:0] al, ah, bl, bh;
  logic [16:0] sa, sb;
  logic [31:0] z0, z2;
  logic [33:0] zm, z1;

  // Three half-width products replace the four of the schoolbook method;
  // the cross term is recovered as (ah+al)(bh+bl) - z2 - z0.
  always_comb begin
    al = a[15:0];
    ah = a[31:16];
    bl = b[15:0];
    bh = b[31:16];
    sa = {1'b0, ah} + {1'b0, al};
    sb = {1'b0, bh} + {1'b0, bl};
    z0 = 32'(al) * 32'(bl);
    z2 = 32'(ah) * 32'(bh);
    zm = 34'(sa) * 34'(sb);
    z1 = zm - {2'b00, z0} - {2'b00, z2};
    c  = {z2, 32'h0000_0000}
       + {14'b0, z1, 16'h0000}
       + {32'h0000_0000, z0};
  end

endmodule

module karatsuba_mul_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  res_valid,
  output logic [63:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [31:0]           ops_done
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic              any_req;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [63:0]       prod;

  logic              ld_op;
  logic              cnt_dec;
  logic              ld_res;
  logic              res_ack;

  // (base + off) mod N_REQ without a divider; off never exceeds N_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  karatsuba_mul_32 u_mul (
    .a (a_q),
    .b (b_q),
    .c (prod)
  );

  // Round-robin pick: first valid requester scanning from ptr with wrap.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any_req && req_valid[wrap_add(ptr, i)]) begin
        grant   = wrap_add(ptr, i);
        any_req = 1'b1;
      end
    end
  end

  // Next-state and per-state control strobes, including the one-hot grant.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    ld_op     = 1'b0;
    cnt_dec   = 1'b0;
    ld_res    = 1'b0;
    res_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[grant] = 1'b1;
          ld_op            = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          ld_res  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (res_valid && res_ready) begin
          res_ack = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Operand capture, settle counter, result register and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      ops_done  <= '0;
    end else begin
      if (ld_op) begin
        a_q  <= req_a[32*grant +: 32];
        b_q  <= req_b[32*grant +: 32];
        id_q <= grant;
        cnt  <= CNT_W'(MUL_CYCLES - 1);
        ptr  <= wrap_add(grant, 1);
      end
      if (cnt_dec) cnt <= cnt - CNT_W'(1);
      if (ld_res) begin
        res_data  <= prod;
        res_id    <= id_q;
        res_valid <= 1'b1;
      end
      if (res_ack) begin
        res_valid <= 1'b0;
        ops_done  <= ops_done + 32'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Self-checking bench for karatsuba_mul_arbiter: one instance with a
// single settle cycle and one with three, sharing the stimulus buses and
// selected by sel3. Expected grants, products, ids and counts come from a
// plain round-robin / arithmetic model kept here.
module tb_karatsuba_mul_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [127:0]  req_a, req_b;
  logic          res_ready;
  logic          sel3;

  logic [3:0]    v1, v3;
  logic [3:0]    rr1, rr3;
  logic          rv1, rv3;
  logic [63:0]   rd1, rd3;
  logic [1:0]    ri1, ri3;
  logic          bz1, bz3;
  logic [31:0]   od1, od3;

  logic [3:0]    o_ready;
  logic          o_valid;
  logic [63:0]   o_data;
  logic [1:0]    o_id;
  logic          o_busy;
  logic [31:0]   o_ops;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            m_ptr [2];
  logic [31:0]   m_ops [2];

  always #5 clk = ~clk;

  assign v1 = sel3 ? 4'b0000 : req_valid;
  assign v3 = sel3 ? req_valid : 4'b0000;

  always_comb begin
    o_ready = sel3 ? rr3 : rr1;
    o_valid = sel3 ? rv3 : rv1;
    o_data  = sel3 ? rd3 : rd1;
    o_id    = sel3 ? ri3 : ri1;
    o_busy  = sel3 ? bz3 : bz1;
    o_ops   = sel3 ? od3 : od1;
  end

  karatsuba_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_CYCLES(1)) dut (
    .clk (clk), .rst (rst), .req_valid (v1), .req_a (req_a), .req_b (req_b),
    .req_ready (rr1), .res_valid (rv1), .res_data (rd1), .res_id (ri1),
    .res_ready (res_ready), .busy (bz1), .ops_done (od1)
  );

  karatsuba_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_CYCLES(3)) dut3 (
    .clk (clk), .rst (rst), .req_valid (v3), .req_a (req_a), .req_b (req_b),
    .req_ready (rr3), .res_valid (rv3), .res_data (rd3), .res_id (ri3),
    .res_ready (res_ready), .busy (bz3), .ops_done (od3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the selected instance; v must be non-zero.
  task automatic run_op(input logic [3:0] v, input logic [127:0] a,
                        input logic [127:0] b, input int stall);
    int          s;
    int          g;
    int          lat;
    logic [63:0] exp_p;
    s   = sel3 ? 1 : 0;
    lat = sel3 ? 3 : 1;
    g   = -1;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_ptr[s] + i) % 4;
      if (g < 0 && v[c]) g = c;
    end
    exp_p = 64'(a[32*g +: 32]) * 64'(b[32*g +: 32]);
    m_ptr[s] = (g + 1) % 4;

    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = (stall == 0);
    #1;
    check("grant", 64'(o_ready), 64'(4'b0001 << g));
    check("idle_busy", 64'(o_busy), 64'd0);
    step();
    for (int k = 0; k < lat; k++) begin
      check("wait_valid", 64'(o_valid), 64'd0);
      check("wait_busy", 64'(o_busy), 64'd1);
      check("wait_ready", 64'(o_ready), 64'd0);
      step();
    end
    check("res_valid", 64'(o_valid), 64'd1);
    check("res_data", o_data, exp_p);
    check("res_id", 64'(o_id), 64'(g));
    for (int k = 0; k < stall; k++) begin
      step();
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_data", o_data, exp_p);
      check("hold_id", 64'(o_id), 64'(g));
      check("hold_busy", 64'(o_busy), 64'd1);
      check("hold_ready", 64'(o_ready), 64'd0);
      check("hold_ops", 64'(o_ops), 64'(m_ops[s]));
    end
    res_ready = 1'b1;
    step();
    m_ops[s] = m_ops[s] + 32'd1;
    check("ack_valid", 64'(o_valid), 64'd0);
    check("ack_ops", 64'(o_ops), 64'(m_ops[s]));
    check("ack_busy", 64'(o_busy), 64'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] a, b;
    sel3      = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0;
    m_ops[0] = '0; m_ops[1] = '0;
    step();
    step();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_id", 64'(o_id), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ops", 64'(o_ops), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_busy3", 64'(bz3), 64'd0);
    rst = 1'b0;

    // No pending request: no grant, stays idle.
    step();
    check("noreq_ready", 64'(o_ready), 64'd0);
    step();
    check("noreq_busy", 64'(o_busy), 64'd0);

    // Fairness with all four held: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) run_op(4'b1111, rnd128(), rnd128(), 0);
    // Only 3, then only 1 and 3: 3,1,3,1.
    run_op(4'b1000, rnd128(), rnd128(), 0);
    for (int i = 0; i < 3; i++) run_op(4'b1010, rnd128(), rnd128(), 0);

    // Single request on requester 2 with known product.
    a = '0; b = '0;
    a[95:64] = 32'h0000_1234;
    b[95:64] = 32'h0000_5678;
    run_op(4'b0100, a, b, 0);
    check("known_prod", o_data, 64'h0000_0000_0626_0060);

    // Extreme operands.
    a = rnd128(); b = rnd128();
    a[31:0] = 32'hFFFF_FFFF;
    b[31:0] = 32'hFFFF_FFFF;
    run_op(4'b0001, a, b, 0);
    check("max_prod", o_data, 64'hFFFF_FFFE_0000_0001);
    a[63:32] = 32'h0;
    b[63:32] = 32'hDEAD_BEEF;
    run_op(4'b0010, a, b, 0);
    check("zero_prod", o_data, 64'd0);

    // Backpressure for ten cycles with other requesters pending.
    run_op(4'b1111, rnd128(), rnd128(), 10);

    // Random traffic.
    for (int i = 0; i < 20; i++)
      run_op(4'($urandom_range(1, 15)), rnd128(), rnd128(), int'($urandom_range(0, 2)));

    // Three-cycle settle instance.
    sel3 = 1'b1;
    req_valid = '0;
    step();
    for (int i = 0; i < 4; i++) run_op(4'b1111, rnd128(), rnd128(), 0);
    run_op(4'b1111, rnd128(), rnd128(), 3);
    for (int i = 0; i < 6; i++)
      run_op(4'($urandom_range(1, 15)), rnd128(), rnd128(), int'($urandom_range(0, 2)));
    run_op(4'b0100, rnd128(), rnd128(), 0);

    // Reset while an operation is waiting on the multiplier.
    req_valid = 4'b0100;
    req_a     = rnd128();
    req_b     = rnd128();
    res_ready = 1'b1;
    #1;
    check("mid_grant", 64'(o_ready), 64'b0100);
    step();
    check("mid_busy", 64'(o_busy), 64'd1);
    rst       = 1'b1;
    req_valid = '0;
    step();
    m_ptr[0] = 0; m_ptr[1] = 0;
    m_ops[0] = '0; m_ops[1] = '0;
    check("mrst_valid", 64'(o_valid), 64'd0);
    check("mrst_data", o_data, 64'd0);
    check("mrst_id", 64'(o_id), 64'd0);
    check("mrst_busy", 64'(o_busy), 64'd0);
    check("mrst_ops", 64'(o_ops), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mrst_nodeliver", 64'(o_valid), 64'd0);
    end
    run_op(4'b1111, rnd128(), rnd128(), 0);
    check("mrst_after_id", 64'(o_id), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
